connect_n_board: RTL and testbench

Parametrised Connect-N game board engine: accepts column drops from the input/control logic, applies gravity, alternates players, and runs a fixed-latency sequential win check around each placed piece. It is the generalised successor of the fixed 6×7 connect-four board. Rows, columns and win length are parameters, and it adds a drop handshake, error reporting, a move counter and a new-game restart. It exposes a combinational cell-read port for the VGA renderer and the `theres_a_winner` / `winner` / `board_full` status used by the system bench.

---
 rtl/connect_n_board.sv | 201 ++++++++++++++++++++
 tb/tb_connect_n_board.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/connect_n_board.sv
// Connect-N board engine: gravity drops, alternating players, and a fixed-latency
// walk of the four lines through the last placed piece to detect a win or a draw.
module connect_n_board #(
    parameter int ROWS    = 6,
    parameter int COLS    = 7,
    parameter int WIN_LEN = 4,
    localparam int CW     = $clog2(COLS),
    localparam int RW     = $clog2(ROWS),
    localparam int MW     = $clog2(ROWS*COLS+1)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          new_game,
    input  logic          drop_valid,
    input  logic [CW-1:0] drop_col,
    output logic          drop_ready,
    output logic          drop_ok,
    output logic          drop_err,
    output logic [1:0]    current_player,
    input  logic [RW-1:0] rd_row,
    input  logic [CW-1:0] rd_col,
    output logic [1:0]    rd_cell,
    output logic          theres_a_winner,
    output logic [1:0]    winner,
    output logic          board_full,
    output logic [MW-1:0] move_count
);

    localparam int HW   = $clog2(ROWS+1);
    localparam int MAXD = (ROWS > COLS) ? ROWS : COLS;
    localparam int PW   = $clog2(MAXD+WIN_LEN) + 2;
    localparam int KW   = $clog2(2*WIN_LEN) + 1;
    localparam logic [KW-1:0] WIN_K  = KW'(WIN_LEN);
    localparam logic [KW-1:0] LAST_K = KW'(WIN_LEN-1);
    localparam logic [MW-1:0] TOTAL  = MW'(ROWS*COLS);

    // Handshake: a drop is taken on any cycle with drop_valid && drop_ready
    // (drop_ready is high only in IDLE) and new_game low; the verdict
    // (drop_ok or drop_err) is a registered one-cycle pulse on the next cycle.
    typedef enum logic [2:0] {S_IDLE, S_PLACE, S_CHECK, S_RESOLVE, S_DONE} state_t;
    state_t state, state_next;

    logic [1:0]    cells   [ROWS][COLS];
    logic [HW-1:0] heights [COLS];
    logic [CW-1:0] col_q;
    logic [RW-1:0] row_q;
    logic [1:0]    player;
    logic [MW-1:0] moves;
    logic          win_flag, full_flag, ok_q, err_q;
    logic [1:0]    winner_q;

    // Line-walk state: direction, side (0 = +, 1 = -), step within the side,
    // whether the run on this side is still unbroken, and the running count.
    logic [1:0]    dir;
    logic          side, alive, win_found;
    logic [KW-1:0] step, run_cnt, cnt_new;
    logic signed [PW-1:0] pr, pc, org_r, org_c, cur_dr, cur_dc;

    function automatic logic signed [PW-1:0] d_row(input logic [1:0] d);
        case (d)
            2'd0:    d_row = '0;
            2'd3:    d_row = -PW'(1);
            default: d_row = PW'(1);
        endcase
    endfunction

    function automatic logic signed [PW-1:0] d_col(input logic [1:0] d);
        d_col = (d == 2'd1) ? '0 : PW'(1);
    endfunction

    logic          col_in_range, col_full, handshake, drop_bad, last_step;
    logic          p_in, hit, rd_in;
    logic [CW-1:0] drop_idx, pc_i;
    logic [RW-1:0] pr_i, row_place;

    always_comb begin
        col_in_range = {1'b0, drop_col} < (CW+1)'(COLS);
        drop_idx     = col_in_range ? drop_col : '0;
        col_full     = heights[drop_idx] == HW'(ROWS);
        handshake    = (state == S_IDLE) && drop_valid && !new_game;
        drop_bad     = !col_in_range || col_full;
        last_step    = step == LAST_K;
        row_place    = heights[col_q][RW-1:0];
        org_r        = $signed(PW'(row_q));
        org_c        = $signed(PW'(col_q));
        cur_dr       = side ? -d_row(dir) : d_row(dir);
        cur_dc       = side ? -d_col(dir) : d_col(dir);
        p_in         = !pr[PW-1] && !pc[PW-1] &&
                       (pr[PW-2:0] < (PW-1)'(ROWS)) && (pc[PW-2:0] < (PW-1)'(COLS));
        pr_i         = p_in ? pr[RW-1:0] : '0;
        pc_i         = p_in ? pc[CW-1:0] : '0;
        hit          = alive && p_in && (cells[pr_i][pc_i] == player);
        cnt_new      = run_cnt + KW'(hit);
        rd_in        = ({1'b0, rd_row} < (RW+1)'(ROWS)) && ({1'b0, rd_col} < (CW+1)'(COLS));
        rd_cell      = rd_in ? cells[rd_row][rd_col] : 2'd0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:    if (handshake && !drop_bad) state_next = S_PLACE;
            S_PLACE:   state_next = S_CHECK;
            S_CHECK:   if (last_step && side && dir == 2'd3) state_next = S_RESOLVE;
            S_RESOLVE: state_next = (win_found || moves == TOTAL) ? S_DONE : S_IDLE;
            S_DONE:    state_next = S_DONE;
            default:   state_next = S_IDLE;
        endcase
        if (new_game) state_next = S_IDLE;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n || new_game) begin
            for (int r = 0; r < ROWS; r++)
                for (int c = 0; c < COLS; c++)
                    cells[r][c] <= 2'd0;
            for (int c = 0; c < COLS; c++) heights[c] <= '0;
            col_q <= '0; row_q <= '0; player <= 2'd1; moves <= '0;
            win_flag <= 1'b0; full_flag <= 1'b0; winner_q <= 2'd0;
            ok_q <= 1'b0; err_q <= 1'b0;
            dir <= '0; side <= 1'b0; alive <= 1'b0; win_found <= 1'b0;
            step <= '0; run_cnt <= '0; pr <= '0; pc <= '0;
        end else begin
            ok_q  <= 1'b0;
            err_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (handshake) begin
                        err_q <= drop_bad;
                        ok_q  <= !drop_bad;
                        if (!drop_bad) col_q <= drop_col;
                    end
                end
                S_PLACE: begin
                    cells[row_place][col_q] <= player;
                    heights[col_q] <= heights[col_q] + HW'(1);
                    moves     <= moves + MW'(1);
                    row_q     <= row_place;
                    dir       <= 2'd0;
                    side      <= 1'b0;
                    step      <= KW'(1);
                    alive     <= 1'b1;
                    run_cnt   <= KW'(1);
                    win_found <= 1'b0;
                    pr        <= $signed(PW'(row_place)) + d_row(2'd0);
                    pc        <= $signed(PW'(col_q)) + d_col(2'd0);
                end
                S_CHECK: begin
                    if (!last_step) begin
                        step    <= step + KW'(1);
                        alive   <= hit;
                        run_cnt <= cnt_new;
                        pr      <= pr + cur_dr;
                        pc      <= pc + cur_dc;
                    end else if (!side) begin
                        side    <= 1'b1;
                        step    <= KW'(1);
                        alive   <= 1'b1;
                        run_cnt <= cnt_new;
                        pr      <= org_r - d_row(dir);
                        pc      <= org_c - d_col(dir);
                    end else begin
                        // Direction finished: judge it, then restart from the placed cell.
                        if (cnt_new >= WIN_K) win_found <= 1'b1;
                        dir     <= dir + 2'd1;
                        side    <= 1'b0;
                        step    <= KW'(1);
                        alive   <= 1'b1;
                        run_cnt <= KW'(1);
                        pr      <= org_r + d_row(dir + 2'd1);
                        pc      <= org_c + d_col(dir + 2'd1);
                    end
                end
                S_RESOLVE: begin
                    if (win_found) begin
                        win_flag <= 1'b1;
                        winner_q <= player;
                    end
                    if (moves == TOTAL) full_flag <= 1'b1;
                    if (!win_found && moves != TOTAL)
                        player <= (player == 2'd1) ? 2'd2 : 2'd1;
                end
                default: ;
            endcase
        end
    end

    assign drop_ready      = (state == S_IDLE);
    assign drop_ok         = ok_q;
    assign drop_err        = err_q;
    assign current_player  = player;
    assign theres_a_winner = win_flag;
    assign winner          = winner_q;
    assign board_full      = full_flag;
    assign move_count      = moves;

endmodule

// File: tb/tb_connect_n_board.sv
// Bench for connect_n_board: default 6x7/4 board plus a 2x2/3 board for the draw case.
module tb_connect_n_board;

    localparam logic [1:0] R_OK  = 2'b01;
    localparam logic [1:0] R_ERR = 2'b10;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_n, new_game, drop_valid, drop_ready, drop_ok, drop_err;
    logic [2:0] drop_col, rd_row, rd_col;
    logic [1:0] current_player, rd_cell, winner;
    logic       theres_a_winner, board_full;
    logic [5:0] move_count;

    logic       ng2, dv2, dr2, ok2, err2, win2, full2;
    logic       dc2, rr2, rc2;
    logic [1:0] pl2, cell2, wnr2;
    logic [2:0] mc2;

    connect_n_board dut (
        .clk(clk), .reset_n(reset_n), .new_game(new_game),
        .drop_valid(drop_valid), .drop_col(drop_col), .drop_ready(drop_ready),
        .drop_ok(drop_ok), .drop_err(drop_err), .current_player(current_player),
        .rd_row(rd_row), .rd_col(rd_col), .rd_cell(rd_cell),
        .theres_a_winner(theres_a_winner), .winner(winner),
        .board_full(board_full), .move_count(move_count)
    );

    connect_n_board #(.ROWS(2), .COLS(2), .WIN_LEN(3)) dut2 (
        .clk(clk), .reset_n(reset_n), .new_game(ng2),
        .drop_valid(dv2), .drop_col(dc2), .drop_ready(dr2),
        .drop_ok(ok2), .drop_err(err2), .current_player(pl2),
        .rd_row(rr2), .rd_col(rc2), .rd_cell(cell2),
        .theres_a_winner(win2), .winner(wnr2),
        .board_full(full2), .move_count(mc2)
    );

    int n_checks = 0;
    int n_fail   = 0;
    logic [1:0] exp_q[$];
    logic [1:0] exp2_q[$];

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every drop_ok/drop_err pulse must match the next queued response.
    initial begin
        logic [1:0] e;
        forever begin
            @(negedge clk);
            if (drop_ok || drop_err) begin
                if (exp_q.size() == 0) chk("resp_unexpected", {drop_err, drop_ok}, 0);
                else begin
                    e = exp_q.pop_front();
                    chk("resp", {drop_err, drop_ok}, e);
                end
            end
            if (ok2 || err2) begin
                if (exp2_q.size() == 0) chk("resp2_unexpected", {err2, ok2}, 0);
                else begin
                    e = exp2_q.pop_front();
                    chk("resp2", {err2, ok2}, e);
                end
            end
        end
    end

    // Called at a negedge with drop_ready high; returns at the negedge after the handshake.
    task automatic drop_start(input int col, input logic [1:0] resp);
        exp_q.push_back(resp);
        drop_valid = 1'b1;
        drop_col   = 3'(col);
        @(negedge clk);
        drop_valid = 1'b0;
    endtask

    task automatic wait_idle(output int lat);
        lat = 1;
        while (!drop_ready && !theres_a_winner && !board_full && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        chk("wait_bound", int'(lat < 200), 1);
    endtask

    task automatic do_drop(input int col, input logic [1:0] resp, output int lat);
        drop_start(col, resp);
        wait_idle(lat);
    endtask

    task automatic pulse_new_game();
        new_game = 1'b1;
        @(negedge clk);
        new_game = 1'b0;
    endtask

    task automatic rd(input int r, input int c, output int v);
        rd_row = 3'(r);
        rd_col = 3'(c);
        #1;
        v = int'(rd_cell);
    endtask

    task automatic count_nonzero(output int nz);
        int v;
        nz = 0;
        for (int r = 0; r < 6; r++)
            for (int c = 0; c < 7; c++) begin
                rd(r, c, v);
                if (v != 0) nz++;
            end
    endtask

    initial begin
        int lat, v, nz;
        int vert[7]  = '{0, 1, 0, 1, 0, 1, 0};
        int diag[11] = '{0, 1, 1, 2, 2, 3, 2, 3, 3, 6, 3};
        int draw[4]  = '{0, 1, 0, 1};

        reset_n = 1'b0; new_game = 1'b0; drop_valid = 1'b0; drop_col = '0;
        rd_row = '0; rd_col = '0;
        ng2 = 1'b0; dv2 = 1'b0; dc2 = 1'b0; rr2 = 1'b0; rc2 = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        // Reset state
        chk("rst_ready", drop_ready, 1);
        chk("rst_player", current_player, 1);
        chk("rst_moves", move_count, 0);
        chk("rst_win", theres_a_winner, 0);
        chk("rst_winner", winner, 0);
        chk("rst_full", board_full, 0);
        chk("rst_okerr", {drop_ok, drop_err}, 0);
        rd(0, 0, v); chk("rst_cell", v, 0);

        // First drop and its 27-cycle turnaround
        @(negedge clk);
        do_drop(3, R_OK, lat);
        chk("first_latency", lat, 27);
        chk("first_player", current_player, 2);
        chk("first_ready", drop_ready, 1);
        chk("first_moves", move_count, 1);
        rd(0, 3, v); chk("first_cell", v, 1);

        // Vertical win for player 1 in column 0
        @(negedge clk);
        pulse_new_game();
        foreach (vert[i]) do_drop(vert[i], R_OK, lat);
        chk("vert_win", theres_a_winner, 1);
        chk("vert_winner", winner, 1);
        chk("vert_full", board_full, 0);
        chk("vert_ready", drop_ready, 0);
        chk("vert_player", current_player, 1);
        drop_valid = 1'b1;
        drop_col   = 3'd2;
        repeat (3) begin
            @(negedge clk);
            chk("done_no_resp", {drop_ok, drop_err}, 0);
        end
        drop_valid = 1'b0;
        chk("done_moves", move_count, 7);

        // Column full and out-of-range column
        pulse_new_game();
        repeat (6) do_drop(2, R_OK, lat);
        do_drop(2, R_ERR, lat);
        chk("full_col_lat", lat, 1);
        chk("full_col_moves", move_count, 6);
        chk("full_col_player", current_player, 1);
        @(negedge clk);
        chk("err_one_cycle", drop_err, 0);
        do_drop(7, R_ERR, lat);
        chk("bad_col_moves", move_count, 6);
        rd(5, 2, v); chk("top_cell", v, 2);
        rd(6, 2, v); chk("rd_row_oob", v, 0);
        rd(0, 7, v); chk("rd_col_oob", v, 0);

        // Diagonal win along (0,0)..(3,3)
        @(negedge clk);
        pulse_new_game();
        for (int i = 0; i < 10; i++) do_drop(diag[i], R_OK, lat);
        chk("diag_no_win_yet", theres_a_winner, 0);
        do_drop(diag[10], R_OK, lat);
        chk("diag_win", theres_a_winner, 1);
        chk("diag_winner", winner, 1);
        chk("diag_moves", move_count, 11);
        rd(3, 3, v); chk("diag_cell", v, 1);

        // Draw on the 2x2 board with WIN_LEN=3
        @(negedge clk);
        foreach (draw[i]) begin
            exp2_q.push_back(R_OK);
            dv2 = 1'b1;
            dc2 = draw[i][0];
            @(negedge clk);
            dv2 = 1'b0;
            lat = 1;
            while (!dr2 && !full2 && !win2 && lat < 200) begin
                @(negedge clk);
                lat++;
            end
            chk("draw_wait_bound", int'(lat < 200), 1);
        end
        chk("draw_full", full2, 1);
        chk("draw_win", win2, 0);
        chk("draw_winner", wnr2, 0);
        chk("draw_ready", dr2, 0);
        chk("draw_moves", mc2, 4);
        rr2 = 1'b1; rc2 = 1'b1; #1;
        chk("draw_cell", cell2, 2);

        // new_game during CHECK of the third move
        @(negedge clk);
        pulse_new_game();
        do_drop(0, R_OK, lat);
        do_drop(1, R_OK, lat);
        drop_start(4, R_OK);
        repeat (5) @(negedge clk);
        new_game   = 1'b1;
        drop_valid = 1'b1;
        drop_col   = 3'd5;
        @(negedge clk);
        new_game   = 1'b0;
        drop_valid = 1'b0;
        chk("ng_moves", move_count, 0);
        chk("ng_player", current_player, 1);
        chk("ng_ready", drop_ready, 1);
        chk("ng_win", theres_a_winner, 0);
        count_nonzero(nz);
        chk("ng_cells_clear", nz, 0);

        // new_game with a simultaneous drop in IDLE: the drop is ignored
        @(negedge clk);
        new_game   = 1'b1;
        drop_valid = 1'b1;
        drop_col   = 3'd0;
        @(negedge clk);
        new_game   = 1'b0;
        drop_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("ng_drop_ignored_moves", move_count, 0);
        rd(0, 0, v); chk("ng_drop_ignored_cell", v, 0);

        // Asynchronous reset during CHECK of the third move
        @(negedge clk);
        do_drop(0, R_OK, lat);
        do_drop(1, R_OK, lat);
        drop_start(4, R_OK);
        repeat (5) @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("arst_moves", move_count, 0);
        chk("arst_player", current_player, 1);
        chk("arst_ready", drop_ready, 1);
        count_nonzero(nz);
        chk("arst_cells_clear", nz, 0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        chk("queue_empty", exp_q.size() + exp2_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
